// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment scanner.
package seg7_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Segment bit positions; SEG_N is the segment bus width.
    typedef enum int {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_N} seg_bit_e;

    localparam logic [SEG_N-1:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: hex nibble to active-high segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_N-1:0] seg_o
);

    assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: round-robin 7-segment scanner with blank gaps and a
// per-frame shadow of the display data.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int DIV_W          = 32,
    parameter int BLANK_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic [DIV_W-1:0]            div_i,
    input  logic [4*N_DIGITS-1:0]       data_i,
    input  logic [N_DIGITS-1:0]         dp_i,
    input  logic [N_DIGITS-1:0]         blank_i,
    output logic [N_DIGITS-1:0]         an_o,
    output logic [SEG_N-1:0]            seg_o,
    output logic                        dp_o,
    output logic [$clog2(N_DIGITS)-1:0] digit_o,
    output logic                        frame_o
);

    localparam int DW = $clog2(N_DIGITS);
    localparam logic [N_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;
    localparam logic [SEG_N-1:0]    SEG_OFF    = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [DIV_W-1:0]    BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0]       LAST_DIGIT = DW'(N_DIGITS - 1);

    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [4*N_DIGITS-1:0] data_q, data_d;
    logic [N_DIGITS-1:0]   dps_q, dps_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [SEG_N-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_q, frame_d;
    logic                  capture;
    logic                  lit;
    logic [3:0]            nibble;
    logic [SEG_N-1:0]      font_seg;

    // The blank count runs up from 0; the drive count runs down from div_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        capture = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = '0;
            capture = 1'b1;
        end else if (state_q == ST_BLANK) begin
            state_d = (cnt_q == BLANK_LAST) ? ST_DRIVE : ST_BLANK;
            cnt_d   = (cnt_q == BLANK_LAST) ? div_i : cnt_q + 1'b1;
        end else if (cnt_q == '0) begin
            state_d = ST_BLANK;
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
            capture = (digit_q == LAST_DIGIT);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        frame_d = capture;
        data_d  = capture ? data_i : data_q;
        dps_d   = capture ? dp_i : dps_q;
        blank_d = capture ? blank_i : blank_q;
    end

    assign nibble = data_d[4*digit_d +: 4];

    seg7_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

    // Outputs are computed for the state being entered so they are registered.
    always_comb begin
        lit  = (state_d == ST_DRIVE) && !blank_d[digit_d];
        an_d = lit ? (AN_OFF ^ (N_DIGITS'(1) << digit_d)) : AN_OFF;
        seg_d = lit ? (font_seg ^ SEG_OFF) : SEG_OFF;
        dp_d = lit ? (dps_d[digit_d] ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
            data_q  <= '0;
            dps_q   <= '0;
            blank_q <= '1;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_ACTIVE_LOW;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            data_q  <= data_d;
            dps_q   <= dps_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign digit_o = digit_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and randomized checks of the scanner against
// a timeline model that queues the expected output of every cycle.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int DW = 8;
    localparam int B = 2;

    logic clk = 1'b0, rst = 1'b0, en_i = 1'b0;
    logic [DW-1:0] div_i = '0;
    logic [4*N-1:0] data_i = '0;
    logic [N-1:0] dp_i = '0, blank_i = '0;
    logic [N-1:0] an_o;
    logic [6:0] seg_o;
    logic dp_o;
    logic [1:0] digit_o;
    logic frame_o;
    int errors = 0, checks = 0;

    seg7_scan_ctrl #(.N_DIGITS(N), .DIV_W(DW), .BLANK_CYCLES(B),
                     .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .div_i(div_i), .data_i(data_i),
        .dp_i(dp_i), .blank_i(blank_i), .an_o(an_o), .seg_o(seg_o),
        .dp_o(dp_o), .digit_o(digit_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic [1:0]   dig;
        logic         fr;
    } exp_t;

    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: a queue of expected cycles, refilled one slot phase at a time.
    bit running = 0, last_drive = 0;
    int cur = 0;
    logic [15:0] sh_data;
    logic [3:0] sh_dp, sh_bl;
    exp_t q[$];
    exp_t e;

    function automatic exp_t off_entry(int d, bit fr);
        return {4'hF, 7'h7F, 1'b1, 2'(d), fr};
    endfunction

    function automatic exp_t lit_entry(int d);
        if (sh_bl[d]) return off_entry(d, 1'b0);
        return {~(4'b0001 << d), ~FONT[sh_data[4*d +: 4]], ~sh_dp[d], 2'(d), 1'b0};
    endfunction

    task automatic capture();
        sh_data = data_i;
        sh_dp = dp_i;
        sh_bl = blank_i;
    endtask

    task automatic step_cycle();
        if (!en_i) begin
            running = 0;
            q.delete();
            e = off_entry(0, 1'b0);
        end else begin
            if (!running) begin
                running = 1;
                capture();
                cur = 0;
                last_drive = 0;
                for (int i = 0; i < B; i++) q.push_back(off_entry(0, i == 0));
            end else if (q.size() == 0) begin
                if (!last_drive) begin
                    for (int i = 0; i <= int'(div_i); i++) q.push_back(lit_entry(cur));
                    last_drive = 1;
                end else begin
                    if (cur == N - 1) capture();
                    for (int i = 0; i < B; i++) q.push_back(off_entry((cur + 1) % N, cur == N - 1 && i == 0));
                    cur = (cur + 1) % N;
                    last_drive = 0;
                end
            end
            e = q.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (an_o !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=f", an_o); end
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_o); end
        checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp_o); end
        checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame_o); end
        checks++; if (digit_o !== 2'd0) begin errors++; $display("FAIL reset_digit got=%0d exp=0", digit_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] an_c [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_c [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        div_i = 8'd3; data_i = 16'h1234; dp_i = '0; blank_i = '0; en_i = 1'b1;
        for (int k = 0; k < 48; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL scan_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            checks++;
            if (frame_o !== (k % 24 == 0)) begin errors++; $display("FAIL scan_frame k=%0d got=%b", k, frame_o); end
            checks++;
            if (k % 6 < 2) begin
                if (an_o !== 4'hF) begin errors++; $display("FAIL scan_blank k=%0d got=%h exp=f", k, an_o); end
            end else if (an_o !== an_c[(k % 24) / 6] || seg_o !== seg_c[(k % 24) / 6]) begin
                errors++; $display("FAIL scan_drive k=%0d got an=%h seg=%b exp an=%h seg=%b", k, an_o, seg_o, an_c[(k % 24) / 6], seg_c[(k % 24) / 6]);
            end
        end
    endtask

    task automatic test_shadow();
        for (int k = 0; k < 54; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL shadow_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            if (k == 8) data_i = 16'hABCD;
            if ((k >= 14 && k <= 17 && seg_o !== 7'b0100100) || (k >= 20 && k <= 23 && seg_o !== 7'b1111001)) begin
                errors++; $display("FAIL shadow_old k=%0d got seg=%b", k, seg_o);
            end
            if (k >= 14 && k <= 23) checks++;
            if (k >= 50 && k <= 53) begin
                checks++;
                if (an_o !== 4'b1110 || seg_o !== 7'b0100001) begin
                    errors++; $display("FAIL shadow_new k=%0d got an=%h seg=%b exp an=e seg=0100001", k, an_o, seg_o);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        blank_i = 4'b0010; dp_i = 4'b0001; data_i = 16'h1234;
        for (int k = 6; k < 48; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL blankdp_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            if (k >= 24) begin
                checks++;
                if (dp_o !== !(k - 24 >= 2 && k - 24 <= 5)) begin
                    errors++; $display("FAIL blankdp_dp p=%0d got=%b", k - 24, dp_o);
                end
                if (k - 24 >= 6 && k - 24 <= 11) begin
                    checks++;
                    if (an_o !== 4'hF || digit_o !== 2'd1) begin
                        errors++; $display("FAIL blankdp_dark p=%0d got an=%h dig=%0d exp an=f dig=1", k - 24, an_o, digit_o);
                    end
                end
            end
        end
        blank_i = '0; dp_i = '0;
    endtask

    task automatic test_div_change();
        logic [3:0] an_c [16] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                                  4'hD, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'h7, 4'hF};
        for (int k = 0; k < 16; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL divchg_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            checks++;
            if (an_o !== an_c[k] || frame_o !== (k == 0 || k == 15)) begin
                errors++; $display("FAIL divchg_seq k=%0d got an=%h fr=%b exp an=%h", k, an_o, frame_o, an_c[k]);
            end
            if (k == 2) div_i = 8'd0;
        end
    endtask

    task automatic test_enable();
        div_i = 8'd3;
        for (int k = 1; k < 21; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL enable_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            if (k == 14) begin
                checks++;
                if (an_o !== 4'b1011) begin errors++; $display("FAIL enable_d2 got an=%h exp=b", an_o); end
                en_i = 1'b0;
            end
            if (k >= 15 && k <= 17) begin
                checks++;
                if (an_o !== 4'hF || digit_o !== 2'd0 || frame_o !== 1'b0 || seg_o !== 7'h7F) begin
                    errors++; $display("FAIL enable_off k=%0d got an=%h dig=%0d fr=%b seg=%h", k, an_o, digit_o, frame_o, seg_o);
                end
            end
            if (k == 17) en_i = 1'b1;
            if (k >= 18) begin
                checks++;
                if (an_o !== (k == 20 ? 4'b1110 : 4'hF) || frame_o !== (k == 18) || digit_o !== 2'd0) begin
                    errors++; $display("FAIL enable_restart k=%0d got an=%h fr=%b dig=%0d", k, an_o, frame_o, digit_o);
                end
            end
        end
    endtask

    task automatic test_div_max();
        int run = 0, longest = 0;
        div_i = 8'hFF;
        for (int k = 0; k < 300; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL divmax_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            run = (an_o === 4'b1101) ? run + 1 : 0;
            if (run > longest) longest = run;
        end
        checks++;
        if (longest != 256) begin errors++; $display("FAIL divmax_len got=%0d exp=256", longest); end
        div_i = 8'd1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL random_model k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
            checks++;
            if ($countones(~an_o) > 1) begin errors++; $display("FAIL random_onehot k=%0d got an=%b", k, an_o); end
            if ($urandom_range(0, 199) == 0) en_i = 1'b0;
            else if (!en_i && $urandom_range(0, 3) == 0) en_i = 1'b1;
            if ($urandom_range(0, 29) == 0) div_i = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) begin
                data_i = 16'($urandom);
                dp_i = 4'($urandom);
                blank_i = 4'($urandom);
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        en_i = 1'b1; div_i = 8'd3; blank_i = '0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step_cycle();
            seen = (an_o !== 4'hF);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL areset_wait got an=%h exp=drive", an_o); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0 || digit_o !== 2'd0) begin
            errors++; $display("FAIL areset_now got an=%h seg=%h dp=%b fr=%b dig=%0d", an_o, seg_o, dp_o, frame_o, digit_o);
        end
        @(negedge clk);
        en_i = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            checks++;
            if ({an_o, seg_o, dp_o, digit_o, frame_o} !== e) begin
                errors++; $display("FAIL areset_idle k=%0d got=%h exp=%h", k, {an_o, seg_o, dp_o, digit_o, frame_o}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_shadow();
        test_blank_dp();
        test_div_change();
        test_enable();
        test_div_max();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display scanner for the board display path.
- Runs entirely on `clk` with an internal slot counter. No derived or divided clocks.
- Drives N_DIGITS anodes in round-robin, with a programmable digit period and a fixed anti-ghosting blank interval.
- Performs hex-to-segment decode, per-digit blanking and decimal-point control.
- Display data is captured once per frame into a shadow register, so the display never tears.

Parameters:
- N_DIGITS, 8, number of multiplexed digits (2..16).
- DIV_W, 32, width of the digit-period reload input.
- BLANK_CYCLES, 16, clk cycles with all anodes off before each digit is driven (≥1).
- AN_ACTIVE_LOW, 1, 1 = anode lines active-low.
- SEG_ACTIVE_LOW, 1, 1 = segment and dp lines active-low.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- en_i, in, 1, scan enable.
- div_i, in, DIV_W, drive cycles per digit minus 1.
- data_i, in, 4*N_DIGITS, hex nibble per digit; digit k = data_i[4k+3:4k].
- dp_i, in, N_DIGITS, decimal point per digit (1 = lit).
- blank_i, in, N_DIGITS, 1 = digit dark.
- an_o, out, N_DIGITS, anode select (registered).
- seg_o, out, 7, segments; bit0 = a … bit6 = g (registered).
- dp_o, out, 1, decimal point (registered).
- digit_o, out, $clog2(N_DIGITS), index of the current digit.
- frame_o, out, 1, one-cycle pulse on shadow capture.

Behaviour:
- Reset values (rst = 0, asynchronous):
  - State IDLE, digit_o = 0, frame_o = 0.
  - an_o, seg_o and dp_o all inactive (polarity per parameters).
  - Shadow blank mask all ones.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs inactive.
  - When en_i = 1: capture data_i, dp_i, blank_i into the shadow; pulse frame_o; digit_o = 0; go to BLANK with blank counter = 0.
- BLANK:
  - an_o, seg_o and dp_o inactive for exactly BLANK_CYCLES cycles.
  - On the last cycle, load the drive counter from div_i (sampled once here) and go to DRIVE.
- DRIVE:
  - Lasts div_i + 1 cycles; div_i = 0 gives 1 cycle.
  - an_o: only bit digit_o active, unless shadow blank[digit_o] = 1, in which case all anodes stay inactive.
  - seg_o = decode(shadow nibble), dp_o = shadow dp[digit_o]; both shown inactive if the digit is blanked.
  - On the last cycle, move to the next digit and go to BLANK:
    - If digit_o = N_DIGITS-1: digit_o wraps to 0, the shadow recaptures and frame_o pulses in that transition cycle.
    - Otherwise: digit_o increments.
- Timing:
  - Slot length = BLANK_CYCLES + div_i + 1.
  - Frame length = N_DIGITS × slot length.
  - No cycle ever has two anodes active.
- Output latency: outputs are registered and change on the clock edge that enters the state. an_o is active exactly during the DRIVE cycles.
- div_i changes mid-slot: no effect on the current DRIVE; applied from the next DRIVE entry.
- data_i, dp_i, blank_i changes mid-frame: invisible until the next frame_o.
- en_i = 0 in any state: next cycle is IDLE with outputs inactive and digit_o = 0. Re-enable restarts from digit 0 with a fresh capture.
- rst mid-operation: outputs go inactive immediately, without waiting for clk.
- Decode: standard hex font 0-F.
  - Active-high form: 0 = 7'h3F, 1 = 7'h06, 2 = 7'h5B, 3 = 7'h4F, 4 = 7'h66, 5 = 7'h6D, 6 = 7'h7D, 7 = 7'h07, 8 = 7'h7F, 9 = 7'h6F, A = 7'h77, b = 7'h7C, C = 7'h39, d = 7'h5E, E = 7'h79, F = 7'h71.
  - Inverted when SEG_ACTIVE_LOW = 1.
- Counters are DIV_W bits and never overflow. A reload of all ones is legal and gives 2^DIV_W drive cycles.

Decomposition:
- Package seg7_pkg holds:
  - the state encoding constants (IDLE, BLANK, DRIVE);
  - the 16-entry active-high hex font constant;
  - the segment bit-index constants.
- Sub-module seg7_hex_decoder: combinational, 4-bit nibble in, 7-bit active-high segments out. Polarity is applied in the top level.

Test Plan:
1. Reset: hold rst = 0 with defaults → an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1, frame_o = 0, digit_o = 0; assert rst mid-DRIVE → same values before the next clk edge.
2. N_DIGITS = 4, BLANK_CYCLES = 2, div_i = 3, data_i = 16'h1234, en_i = 1 → frame_o pulses; per 6-cycle slot, 2 cycles an_o = 4'hF then 4 cycles active.
   - Digit 0: an_o = 4'b1110, seg_o = 7'b0011001 ('4').
   - Digits 1-3 follow with '3', '2', '1'.
   - frame_o repeats every 24 cycles.
3. Shadow: change data_i to 16'hABCD during digit 1 DRIVE → digits 2-3 still show '2', '1'; 'D' appears on digit 0 only after the next frame_o.
4. blank_i = 4'b0010, dp_i = 4'b0001 → digit 1 slot keeps 6 cycles with an_o = 4'hF throughout; dp_o = 0 only during digit 0 DRIVE.
5. div_i changed 3 → 0 during digit 0 DRIVE → digit 0 still drives 4 cycles; later slots are 3 cycles (2 blank + 1 drive).
6. en_i dropped in DRIVE of digit 2 → next cycle an_o = 4'hF, digit_o = 0; re-raise → frame_o pulses and the scan restarts at digit 0 after 2 blank cycles.
